// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the fetch and load/store ports.
// Optional feature macro: MEM_BUS_TIMEOUT_EN (waitrequest timeout with bus_err).
`default_nettype none

module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                busy,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  state_t state;
  logic   grant_data;

  // Fetches are always word aligned, so the low address bits never reach the bus.
  logic unused_if_addr_bits;
  assign unused_if_addr_bits = ^if_addr[1:0];

  assign busy = (state != IDLE);

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  assign timed_out = waitrequest && (wait_cnt == LAST_WAIT);
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_data <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      wait_cnt   <= '0;
      bus_err    <= 1'b0;
`endif
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef MEM_BUS_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          // A port still showing its done pulse is not re-granted on this edge.
          if (d_req && !d_done) begin
            grant_data <= 1'b1;
            address    <= d_addr;
            writedata  <= d_wdata;
            byteenable <= d_be;
            if (d_we) begin
              write <= 1'b1;
              state <= WR_REQ;
            end else begin
              read  <= 1'b1;
              state <= RD_REQ;
            end
          end else if (if_req && !if_done) begin
            grant_data <= 1'b0;
            address    <= {if_addr[ADDR_W-1:2], 2'b00};
            writedata  <= '0;
            byteenable <= '1;
            read       <= 1'b1;
            state      <= RD_REQ;
          end
        end

        RD_REQ: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            state <= RD_DATA;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (timed_out) begin
            read    <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
            if (grant_data) begin
              d_rdata <= '0;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= '0;
              if_done  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        RD_DATA: begin
          state <= IDLE;
          if (grant_data) begin
            d_rdata <= readdata;
            d_done  <= 1'b1;
          end else begin
            if_rdata <= readdata;
            if_done  <= 1'b1;
          end
        end

        WR_REQ: begin
          if (!waitrequest) begin
            write  <= 1'b0;
            d_done <= 1'b1;
            state  <= IDLE;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (timed_out) begin
            write   <= 1'b0;
            d_done  <= 1'b1;
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_strobe_exclusive : assert property (@(posedge clk) disable iff (reset) !(read && write));

`ifndef MEM_BUS_TIMEOUT_EN
  // Without the timeout a stalled strobe and its qualifiers must not move.
  a_read_stable : assert property (@(posedge clk) disable iff (reset)
    (read && waitrequest) |=> (read && $stable(address) && $stable(byteenable)));
  a_write_stable : assert property (@(posedge clk) disable iff (reset)
    (write && waitrequest) |=> (write && $stable(address) && $stable(writedata) && $stable(byteenable)));
`endif

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Multi-cycle sequencer sharing the CPU's single memory bus between the instruction-fetch port and the data (load/store) port.
- Accepts level-held requests, arbitrates, drives one bus transaction at a time with waitrequest handshaking, and returns read data with a one-cycle done pulse.
- Sits between the fetch/load-store datapath and the external memory-mapped bus master interface; `busy` feeds the core's stall logic.

Parameters:
- ADDR_W, 32, bus/request address width in bits.
- DATA_W, 32, bus data width in bits; byteenable width is DATA_W/8.
- TIMEOUT_CYCLES, 255, waitrequest-high cycle limit; used only with MEM_BUS_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] are forced to 0 on the bus.
- if_rdata  out  DATA_W  registered fetch data; valid while if_done is high, held until the next fetch completes.
- if_done  out  1  one-cycle completion pulse for the fetch port.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  data byteenable.
- d_rdata  out  DATA_W  registered load data; valid while d_done is high, held until the next data read completes.
- d_done  out  1  one-cycle completion pulse for the data port.
- busy  out  1  high whenever state != IDLE.
- bus_err  out  1  one-cycle pulse coincident with a done pulse on timeout; tied 0 without the macro.
- address  out  ADDR_W  bus address.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- writedata  out  DATA_W  bus write data.
- byteenable  out  DATA_W/8  bus byteenable.
- waitrequest  in  1  bus stall; the current strobe must be held while it is high.
- readdata  in  DATA_W  bus read data; valid the cycle after read is accepted.

Behaviour:
- Reset (async): state IDLE. All outputs 0, including if_rdata, d_rdata, done pulses, busy, bus_err, address, strobes, writedata and byteenable.
  - Reset mid-transaction drops read/write immediately; no done pulse is produced.
- States: IDLE, RD_REQ, RD_DATA, WR_REQ.
- IDLE: at the rising edge, sample requests.
  - A port whose done is high in the current cycle is ignored.
  - d_req has fixed priority over if_req.
  - On grant: latch port id, address, wdata and be into registers. Fetch always uses be = all-ones and addr[1:0] = 0.
  - Next state: WR_REQ if data with d_we = 1, else RD_REQ.
- RD_REQ: drive read = 1 with the latched address/byteenable. At an edge with waitrequest = 0, go to RD_DATA; otherwise stay with outputs unchanged.
- RD_DATA: read = 0. At the edge, capture readdata into the granted port's rdata register, assert that port's done for the next cycle, and go to IDLE.
- WR_REQ: drive write = 1, writedata, byteenable. At an edge with waitrequest = 0, assert d_done for the next cycle and go to IDLE.
- read and write are never high together. Bus outputs are stable for the entire waitrequest-high period.
- Latency with waitrequest always 0:
  - Read: request sampled at edge 0 -> read high in cycle 1 -> done high in cycle 3.
  - Write: request sampled at edge 0 -> write high in cycle 1 -> done high in cycle 2.
- The ungranted request stays pending and is granted at the first IDLE edge where it is eligible. A data request arriving while a fetch is in flight waits; there is no preemption.
- Requester inputs changing after grant have no effect on the bus.
- Back-to-back: one IDLE cycle always separates transactions, namely the cycle carrying the done pulse.

Optional Feature:
- Macro MEM_BUS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to RD_REQ/WR_REQ and increments each cycle waitrequest is high.
  - On reaching TIMEOUT_CYCLES, drop the strobe and go to IDLE. Pulse the granted port's done together with bus_err in the next cycle.
  - On a read timeout, the port's rdata is set to 0.
- Undefined: no counter; waits indefinitely; bus_err constant 0.

Test Plan:
- Reset then if_req = 1, if_addr = 0xBFC00003, waitrequest = 0, readdata = 0x3C010001 -> read high cycle 1 with address 0xBFC00000, be = 0xF; if_done cycle 3 with if_rdata = 0x3C010001; busy high cycles 1–2.
- d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, d_be = 0x3, waitrequest high 4 cycles -> write/address/writedata/be stable for 5 cycles; d_done one cycle after acceptance.
- if_req and d_req (read, 0x200) raised same cycle -> data read serviced first, fetch issued after the d_done cycle; if_done follows.
- Assert reset while RD_REQ with waitrequest high -> read and all outputs 0 immediately; no done pulse; fresh if_req afterwards completes normally.
- Consecutive fetches 0x0, 0x4 with req held high after if_done -> second fetch granted only after the done cycle; exactly two if_done pulses.
- MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES = 4, waitrequest stuck 1 on a data read -> read drops after 4 high cycles; d_done and bus_err pulse together; d_rdata = 0.
